// File: rtl/arb_requester.sv
// Requester agent for the two-port fair arbiter: command FIFO + req/burst FSM.
// Optional REQ_TIMEOUT_EN build aborts a request left ungranted for TIMEOUT cycles.
module arb_requester #(
   parameter int DEPTH   = 4,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             req,
   input  logic             grant,
   output logic             beat_valid,
   output logic             beat_last,
   output logic             busy,
   output logic             timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

   state_t state, state_nxt;

   logic [LEN_W-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [LEN_W-1:0] len_r, beat_cnt;
   logic full, empty, push, pop, expire;

   assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign cmd_ready = !full && !reset;
   assign push = cmd_valid && cmd_ready;
   assign pop = (state == IDLE) && !empty;
   assign wr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
   assign rd_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;
   assign beat_valid = (state == XFER) && grant;
   assign beat_last = beat_valid && (beat_cnt == len_r);

`ifdef REQ_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WAIT_ONE = WW'(1);

   logic [WW-1:0] wait_cnt;
   logic timeout_r;

   // expiry is the TIMEOUT-th ungranted REQ cycle; a grant then still wins
   assign expire = (state == REQ) && !grant && (wait_cnt == WAIT_MAX);
   assign timeout = timeout_r;

   // wait counter: zero outside REQ, counts ungranted REQ cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= expire;
         if (state != REQ)
            wait_cnt <= '0;
         else if (!grant)
            wait_cnt <= wait_cnt + WAIT_ONE;
      end
   end
`else
   assign expire = 1'b0;
   assign timeout = 1'b0;
`endif

   // next-state: queue -> request -> burst -> one-cycle release gap
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (!empty) state_nxt = REQ;
         REQ: begin
            if (grant) state_nxt = XFER;
            else if (expire) state_nxt = GAP;
         end
         XFER: if (beat_last) state_nxt = GAP;
         GAP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // command storage; no reset needed, pointers define validity
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= cmd_len;
   end

   // state, pointers, burst counter and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         len_r <= '0;
         beat_cnt <= '0;
         req <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_nxt;
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         req <= (state_nxt == REQ) || (state_nxt == XFER);
         busy <= (state_nxt != IDLE) || (wr_nxt != rd_nxt);
         if (pop) begin
            len_r <= mem[rd_ptr[AW-1:0]];
            beat_cnt <= '0;
         end else if (beat_valid) begin
            beat_cnt <= beat_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: reset, single beat, stall, full FIFO,
// mid-burst reset and request timeout (REQ_TIMEOUT_EN) or its absence.
module tb_arb_requester;

   logic clk = 1'b0;
   logic reset, cmd_valid, grant;
   logic [3:0] cmd_len;
   logic cmd_ready, req, beat_valid, beat_last, busy, timeout;

   int tests = 0;
   int fails = 0;
   int beats = 0;
   int lasts = 0;
   int touts = 0;
   int badlast = 0;

   arb_requester #(.DEPTH(4), .LEN_W(4), .TIMEOUT(8)) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_len(cmd_len),
      .req(req),
      .grant(grant),
      .beat_valid(beat_valid),
      .beat_last(beat_last),
      .busy(busy),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   // observe outputs mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (beat_valid) beats++;
      if (beat_valid && beat_last) lasts++;
      if (beat_last && !beat_valid) badlast++;
      if (timeout) touts++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 1'b1; cmd_len = 4'd5; grant = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", req); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
      tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rst_tout: got %b want 0", timeout); end
      reset = 1'b0; cmd_valid = 1'b0;
      #1;
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_rel: got %b want 1", cmd_ready); end
      cyc(); cyc();
      @(negedge clk);
      tests++; if ({busy, req} !== 2'b00) begin fails++; $display("FAIL rst_empty: busy,req got %b want 00", {busy, req}); end
   endtask

   task automatic test_single_beat();
      int b0;
      cyc();
      b0 = beats;
      cmd_valid = 1'b1; cmd_len = 4'd0; grant = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
      tests++; if ({req, beat_valid, busy} !== 3'b001) begin fails++; $display("FAIL sb_idle: req,bv,busy got %b want 001", {req, beat_valid, busy}); end
      cyc();
      @(negedge clk);
      tests++; if ({req, beat_valid} !== 2'b10) begin fails++; $display("FAIL sb_req: req,bv got %b want 10", {req, beat_valid}); end
      cyc();
      @(negedge clk);
      tests++; if ({req, beat_valid, beat_last} !== 3'b111) begin fails++; $display("FAIL sb_beat: req,bv,bl got %b want 111", {req, beat_valid, beat_last}); end
      cyc();
      @(negedge clk);
      tests++; if ({req, beat_valid, busy} !== 3'b001) begin fails++; $display("FAIL sb_gap: req,bv,busy got %b want 001", {req, beat_valid, busy}); end
      cyc();
      tests++; if (beats - b0 !== 1) begin fails++; $display("FAIL sb_count: got %0d want 1", beats - b0); end
      @(negedge clk);
      tests++; if ({req, busy} !== 2'b00) begin fails++; $display("FAIL sb_idle2: req,busy got %b want 00", {req, busy}); end
      grant = 1'b0;
   endtask

   task automatic test_stall();
      int b0, l0;
      logic [5:0] pat;
      pat = 6'b110011;
      cyc();
      b0 = beats; l0 = lasts;
      cmd_valid = 1'b1; cmd_len = 4'd3; grant = 1'b0;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      grant = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         grant = pat[i];
         @(negedge clk);
         tests++;
         if ({req, beat_valid, beat_last} !== {1'b1, pat[i], (i == 5)}) begin
            fails++;
            $display("FAIL stall_%0d: req,bv,bl got %b want %b", i,
                     {req, beat_valid, beat_last}, {1'b1, pat[i], (i == 5)});
         end
         cyc();
      end
      grant = 1'b0;
      tests++; if (beats - b0 !== 4) begin fails++; $display("FAIL stall_beats: got %0d want 4", beats - b0); end
      tests++; if (lasts - l0 !== 1) begin fails++; $display("FAIL stall_lasts: got %0d want 1", lasts - l0); end
      @(negedge clk);
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL stall_gap: req got %b want 0", req); end
      cyc();
   endtask

   task automatic test_full_fifo();
      int b0, l0, n;
      int lens [6];
      logic [5:0] rdy;
      lens = '{0, 1, 0, 1, 0, 2};
      cyc();
      b0 = beats; l0 = lasts;
      grant = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_len = 4'(lens[i]);
         @(negedge clk);
         rdy[i] = cmd_ready;
         cyc();
      end
      cmd_valid = 1'b0;
      tests++; if (rdy !== 6'b011111) begin fails++; $display("FAIL full_ready: got %b want 011111", rdy); end
      tests++; if (req !== 1'b1) begin fails++; $display("FAIL full_req: got %b want 1", req); end
      grant = 1'b1;
      n = 0;
      while (busy && n < 300) begin
         cyc();
         n++;
      end
      tests++; if (n >= 300) begin fails++; $display("FAIL full_drain: busy still %b after %0d cycles want 0", busy, n); end
      cyc();
      tests++; if (beats - b0 !== 7) begin fails++; $display("FAIL full_beats: got %0d want 7", beats - b0); end
      tests++; if (lasts - l0 !== 5) begin fails++; $display("FAIL full_bursts: got %0d want 5", lasts - l0); end
      grant = 1'b0;
   endtask

   task automatic test_mid_reset();
      int b0;
      cyc();
      b0 = beats;
      cmd_valid = 1'b1; cmd_len = 4'd7; grant = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      cyc(); cyc(); cyc(); cyc(); cyc();
      reset = 1'b1;
      cyc();
      @(negedge clk);
      tests++; if ({req, beat_valid, busy, cmd_ready} !== 4'b0000) begin fails++; $display("FAIL mr_after: req,bv,busy,rdy got %b want 0000", {req, beat_valid, busy, cmd_ready}); end
      reset = 1'b0;
      repeat (5) cyc();
      tests++; if (beats - b0 !== 4) begin fails++; $display("FAIL mr_beats: got %0d want 4", beats - b0); end
      tests++; if ({req, busy} !== 2'b00) begin fails++; $display("FAIL mr_idle: req,busy got %b want 00", {req, busy}); end
      grant = 1'b0;
   endtask

`ifdef REQ_TIMEOUT_EN
   task automatic test_timeout();
      int t0, n;
      cyc();
      t0 = touts;
      cmd_valid = 1'b1; cmd_len = 4'd0; grant = 1'b0;
      cyc();
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
      tests++; if (req !== 1'b1) begin fails++; $display("FAIL to_rise: req got %b want 1", req); end
      for (int k = 1; k < 8; k++) begin
         cyc();
         @(negedge clk);
         tests++; if ({timeout, req} !== 2'b01) begin fails++; $display("FAIL to_wait_%0d: tout,req got %b want 01", k, {timeout, req}); end
      end
      cyc();
      @(negedge clk);
      tests++; if ({timeout, req} !== 2'b10) begin fails++; $display("FAIL to_pulse: tout,req got %b want 10", {timeout, req}); end
      cyc();
      @(negedge clk);
      tests++; if ({timeout, req} !== 2'b00) begin fails++; $display("FAIL to_gap: tout,req got %b want 00", {timeout, req}); end
      cyc();
      @(negedge clk);
      tests++; if (req !== 1'b1) begin fails++; $display("FAIL to_rereq: req got %b want 1", req); end
      grant = 1'b1;
      n = 0;
      while (busy && n < 100) begin
         cyc();
         n++;
      end
      cyc();
      tests++; if (n >= 100) begin fails++; $display("FAIL to_drain: busy %b after %0d cycles want 0", busy, n); end
      tests++; if (touts - t0 !== 1) begin fails++; $display("FAIL to_count: got %0d want 1", touts - t0); end
      grant = 1'b0;
   endtask
`else
   task automatic test_timeout();
      int b0, n;
      cyc();
      b0 = beats;
      cmd_valid = 1'b1; cmd_len = 4'd0; grant = 1'b0;
      cyc();
      cmd_valid = 1'b0;
      repeat (30) cyc();
      @(negedge clk);
      tests++; if ({req, timeout} !== 2'b10) begin fails++; $display("FAIL nto_wait: req,tout got %b want 10", {req, timeout}); end
      cyc();
      grant = 1'b1;
      n = 0;
      while (busy && n < 100) begin
         cyc();
         n++;
      end
      cyc();
      tests++; if (n >= 100) begin fails++; $display("FAIL nto_drain: busy %b after %0d cycles want 0", busy, n); end
      tests++; if (beats - b0 !== 1) begin fails++; $display("FAIL nto_beats: got %0d want 1", beats - b0); end
      tests++; if (touts !== 0) begin fails++; $display("FAIL nto_pulses: got %0d want 0", touts); end
      grant = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; grant = 1'b0;
      test_reset();
      test_single_beat();
      test_stall();
      test_full_fifo();
      test_mid_reset();
      test_timeout();
      tests++; if (badlast !== 0) begin fails++; $display("FAIL last_gated: got %0d stray beat_last want 0", badlast); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
